// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - encodings, timing constants and shadow-slot types for hazard_ctrl
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [4:0] RT_BGEZ = 5'd1;
  localparam logic [4:0] REG_RA  = 5'd31;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] T_0    = 2'd0;
  localparam logic [1:0] T_1    = 2'd1;
  localparam logic [1:0] T_2    = 2'd2;
  localparam logic [1:0] T_NONE = 2'd3;

  // Source addresses are held as 0 when the instruction does not read them.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
  } slot_e_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] tnew;
  } slot_m_t;

  typedef struct packed {
    logic [4:0] wa;
  } slot_w_t;

  function automatic logic hit(input logic [4:0] src, input logic [4:0] wa);
    return (src != 5'd0) && (src == wa);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input slot_m_t m, input slot_w_t w);
    if (hit(src, m.wa) && (m.tnew == T_0)) return FWD_M;
    if (hit(src, w.wa)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_decode.sv
// rtl/hazard_ctrl_decode.sv - D-stage decode of source/dest addresses, Tuse and Tnew
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_wa,
  output logic [1:0]  o_tuse_rs,
  output logic [1:0]  o_tuse_rt,
  output logic [1:0]  o_tnew
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs_f;
  logic [4:0] w_rt_f;
  logic [4:0] w_rd_f;

  assign w_op    = i_instr[31:26];
  assign w_rs_f  = i_instr[25:21];
  assign w_rt_f  = i_instr[20:16];
  assign w_rd_f  = i_instr[15:11];
  assign w_funct = i_instr[5:0];

  always_comb begin
    o_tuse_rs = T_NONE;
    o_tuse_rt = T_NONE;
    o_wa      = 5'd0;
    o_tnew    = T_0;
    case (w_op)
      OP_RTYPE: begin
        if (w_funct == FN_ADDU || w_funct == FN_SUBU) begin
          o_tuse_rs = T_1;
          o_tuse_rt = T_1;
          o_wa      = w_rd_f;
          o_tnew    = T_1;
        end else if (w_funct == FN_JR) begin
          o_tuse_rs = T_0;
        end
      end
      OP_REGIMM: if (w_rt_f == RT_BGEZ) o_tuse_rs = T_0;
      OP_BEQ: begin
        o_tuse_rs = T_0;
        o_tuse_rt = T_0;
      end
      OP_ORI: begin
        o_tuse_rs = T_1;
        o_wa      = w_rt_f;
        o_tnew    = T_1;
      end
      OP_LUI: begin
        o_wa   = w_rt_f;
        o_tnew = T_1;
      end
      OP_LW: begin
        o_tuse_rs = T_1;
        o_wa      = w_rt_f;
        o_tnew    = T_2;
      end
      OP_SW: begin
        o_tuse_rs = T_1;
        o_tuse_rt = T_2;
      end
      OP_JAL: begin
        o_wa   = REG_RA;
        o_tnew = T_1;
      end
      default: ;
    endcase
  end

  // Unused sources collapse to $0 so they can never match a slot.
  assign o_rs = (o_tuse_rs != T_NONE) ? w_rs_f : 5'd0;
  assign o_rt = (o_tuse_rt != T_NONE) ? w_rt_f : 5'd0;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - shadow E/M/W slots, stall and forwarding select generation
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  output logic        Stall,
  output logic [1:0]  ForwardRSD,
  output logic [1:0]  ForwardRTD,
  output logic [1:0]  ForwardRSE,
  output logic [1:0]  ForwardRTE,
  output logic        ForwardRTM
);

  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_wa;
  logic [1:0] w_tuse_rs;
  logic [1:0] w_tuse_rt;
  logic [1:0] w_tnew;
  logic       w_stall_e;
  logic       w_stall_m;

  slot_e_t r_e;
  slot_m_t r_m;
  slot_w_t r_w;

  hazard_decode u_decode (
    .i_instr   (Instr_D),
    .o_rs      (w_rs),
    .o_rt      (w_rt),
    .o_wa      (w_wa),
    .o_tuse_rs (w_tuse_rs),
    .o_tuse_rt (w_tuse_rt),
    .o_tnew    (w_tnew)
  );

  assign w_stall_e = (hit(w_rs, r_e.wa) && (w_tuse_rs < r_e.tnew)) ||
                     (hit(w_rt, r_e.wa) && (w_tuse_rt < r_e.tnew));
  assign w_stall_m = (hit(w_rs, r_m.wa) && (w_tuse_rs < r_m.tnew)) ||
                     (hit(w_rt, r_m.wa) && (w_tuse_rt < r_m.tnew));
  assign Stall     = w_stall_e | w_stall_m;

  assign ForwardRSD = fwd_sel(w_rs, r_m, r_w);
  assign ForwardRTD = fwd_sel(w_rt, r_m, r_w);
  assign ForwardRSE = fwd_sel(r_e.rs, r_m, r_w);
  assign ForwardRTE = fwd_sel(r_e.rt, r_m, r_w);
  assign ForwardRTM = hit(r_m.rt, r_w.wa);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w.wa   <= r_m.wa;
      r_m.rt   <= r_e.rt;
      r_m.wa   <= r_e.wa;
      r_m.tnew <= (r_e.tnew == T_0) ? T_0 : r_e.tnew - 2'd1;
      // A held D instruction leaves a bubble behind it in E.
      if (Stall) begin
        r_e <= '0;
      end else begin
        r_e.rs   <= w_rs;
        r_e.rt   <= w_rt;
        r_e.wa   <= w_wa;
        r_e.tnew <= w_tnew;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized bench for hazard_ctrl against a pipeline model
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr_D = 32'd0;
  logic        Stall;
  logic [1:0]  ForwardRSD, ForwardRTD, ForwardRSE, ForwardRTE;
  logic        ForwardRTM;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Instr_D    (Instr_D),
    .Stall      (Stall),
    .ForwardRSD (ForwardRSD),
    .ForwardRTD (ForwardRTD),
    .ForwardRSE (ForwardRSE),
    .ForwardRTE (ForwardRTE),
    .ForwardRTM (ForwardRTM)
  );

  always #5 clk = ~clk;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5, K_BEQ = 6;
  localparam int K_BGEZ = 7, K_JR = 8, K_J = 9, K_JAL = 10, K_NOP = 11, K_UND = 12;

  typedef struct {
    logic [31:0] ins;
    int rs;
    int rt;
    int tu_rs;
    int tu_rt;
    int wa;
    int tnew;
  } rec_t;

  int   n_pass = 0;
  int   n_tot  = 0;
  rec_t me, mm, mw, bub;
  logic [1:0] l_rsd, l_rtd, l_rse, l_rte;
  logic       l_rtm;

  function automatic rec_t mk(int k, int s, int t, int d);
    rec_t r;
    r.ins = 32'd0; r.rs = s; r.rt = t; r.tu_rs = -1; r.tu_rt = -1; r.wa = 0; r.tnew = 0;
    case (k)
      K_ADDU, K_SUBU: begin
        r.ins = {6'h00, s[4:0], t[4:0], d[4:0], 5'd0, (k == K_ADDU) ? 6'h21 : 6'h23};
        r.tu_rs = 1; r.tu_rt = 1; r.wa = d; r.tnew = 1;
      end
      K_ORI:  begin r.ins = {6'h0d, s[4:0], t[4:0], 16'h0009}; r.tu_rs = 1; r.wa = t; r.tnew = 1; end
      K_LUI:  begin r.ins = {6'h0f, 5'd0, t[4:0], 16'h1234}; r.wa = t; r.tnew = 1; end
      K_LW:   begin r.ins = {6'h23, s[4:0], t[4:0], 16'h0000}; r.tu_rs = 1; r.wa = t; r.tnew = 2; end
      K_SW:   begin r.ins = {6'h2b, s[4:0], t[4:0], 16'h0004}; r.tu_rs = 1; r.tu_rt = 2; end
      K_BEQ:  begin r.ins = {6'h04, s[4:0], t[4:0], 16'h0002}; r.tu_rs = 0; r.tu_rt = 0; end
      K_BGEZ: begin r.ins = {6'h01, s[4:0], 5'd1, 16'h0002}; r.tu_rs = 0; end
      K_JR:   begin r.ins = {6'h00, s[4:0], 15'd0, 6'h08}; r.tu_rs = 0; end
      K_J:    r.ins = {6'h02, 26'h0000010};
      K_JAL:  begin r.ins = {6'h03, 26'h0000010}; r.wa = 31; r.tnew = 1; end
      K_UND:  r.ins = {6'h3f, s[4:0], t[4:0], d[4:0], 11'h7ff};
      default: r.ins = 32'd0;
    endcase
    if (r.tu_rs < 0) r.rs = 0;
    if (r.tu_rt < 0) r.rt = 0;
    return r;
  endfunction

  function automatic bit hit(int src, int wa);
    return (src != 0) && (src == wa);
  endfunction

  // Result readiness counts down one per stage after entering E.
  function automatic int rem_m();
    return (mm.tnew > 0) ? mm.tnew - 1 : 0;
  endfunction

  function automatic int fsel(int src);
    if (hit(src, mm.wa) && rem_m() == 0) return 2;
    if (hit(src, mw.wa)) return 1;
    return 0;
  endfunction

  function automatic bit mstall(rec_t d);
    return (hit(d.rs, me.wa) && d.tu_rs < me.tnew) || (hit(d.rt, me.wa) && d.tu_rt < me.tnew) ||
           (hit(d.rs, mm.wa) && d.tu_rs < rem_m()) || (hit(d.rt, mm.wa) && d.tu_rt < rem_m());
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic compare(input rec_t d);
    chk("stall", Stall, mstall(d));
    chk("fwd_rsd", ForwardRSD, fsel(d.rs));
    chk("fwd_rtd", ForwardRTD, fsel(d.rt));
    chk("fwd_rse", ForwardRSE, fsel(me.rs));
    chk("fwd_rte", ForwardRTE, fsel(me.rt));
    chk("fwd_rtm", ForwardRTM, hit(mm.rt, mw.wa));
    l_rsd = ForwardRSD; l_rtd = ForwardRTD; l_rse = ForwardRSE; l_rte = ForwardRTE; l_rtm = ForwardRTM;
  endtask

  task automatic do_reset(input rec_t r, input int cyc);
    reset = 1'b0;
    Instr_D = r.ins;
    repeat (cyc) begin
      @(posedge clk);
      #1;
    end
    me = bub; mm = bub; mw = bub;
    compare(r);
    reset = 1'b1;
  endtask

  // Holds r in D until the model accepts it; n returns the stall cycles the DUT showed.
  task automatic run_instr(input rec_t r, output int n);
    bit st;
    n = 0;
    Instr_D = r.ins;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      st = mstall(r);
      compare(r);
      if (Stall === 1'b1) n++;
      @(posedge clk);
      mw = mm; mm = me; me = st ? bub : r;
      #1;
      if (!st) break;
    end
  endtask

  initial begin
    int n;
    int pool[5] = '{0, 1, 2, 3, 31};
    rec_t r;
    bub = mk(K_NOP, 0, 0, 0);
    me = bub; mm = bub; mw = bub;

    do_reset(mk(K_ADDU, 1, 2, 3), 2);
    run_instr(mk(K_ADDU, 1, 2, 3), n);
    run_instr(mk(K_ADDU, 3, 3, 4), n);
    chk("alu_alu_stalls", n, 0);
    run_instr(bub, n);
    chk("alu_alu_rse", l_rse, 2);
    chk("alu_alu_rte", l_rte, 2);
    run_instr(bub, n);
    chk("unrelated_rse", l_rse, 0);

    run_instr(mk(K_LW, 0, 5, 0), n);
    run_instr(mk(K_ORI, 5, 6, 0), n);
    chk("lw_alu_stalls", n, 1);
    run_instr(bub, n);
    chk("lw_alu_rse_w", l_rse, 1);

    run_instr(mk(K_ORI, 0, 7, 0), n);
    run_instr(mk(K_BEQ, 7, 7, 0), n);
    chk("alu_beq_stalls", n, 1);
    chk("alu_beq_rsd", l_rsd, 2);
    chk("alu_beq_rtd", l_rtd, 2);

    run_instr(mk(K_LW, 0, 8, 0), n);
    run_instr(mk(K_SW, 0, 8, 0), n);
    chk("lw_sw_stalls", n, 0);
    run_instr(bub, n);
    run_instr(bub, n);
    chk("lw_sw_rtm", l_rtm, 1);

    run_instr(mk(K_JAL, 0, 0, 0), n);
    run_instr(mk(K_JR, 31, 0, 0), n);
    chk("jal_jr_stalls", n, 1);
    chk("jal_jr_rsd", l_rsd, 2);

    run_instr(mk(K_ADDU, 1, 2, 0), n);
    run_instr(mk(K_BEQ, 0, 0, 0), n);
    chk("r0_beq_stalls", n, 0);
    chk("r0_beq_rsd", l_rsd, 0);
    run_instr(mk(K_ADDU, 0, 0, 5), n);
    chk("r0_alu_stalls", n, 0);

    run_instr(mk(K_LW, 0, 9, 0), n);
    run_instr(mk(K_BEQ, 9, 9, 0), n);
    chk("lw_beq_stalls", n, 2);
    chk("lw_beq_rsd_w", l_rsd, 1);

    run_instr(mk(K_LW, 0, 9, 0), n);
    r = mk(K_ORI, 9, 10, 0);
    Instr_D = r.ins;
    @(negedge clk);
    compare(r);
    chk("mid_stall_seen", Stall, 1);
    do_reset(r, 1);
    run_instr(r, n);
    chk("mid_stall_reset_stalls", n, 0);

    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, K_UND), pool[$urandom_range(0, 4)], pool[$urandom_range(0, 4)],
             pool[$urandom_range(0, 4)]);
      if ($urandom_range(0, 59) == 0) do_reset(r, 1);
      run_instr(r, n);
      chk("rand_stall_le2", (n <= 2), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall and forwarding controller for the five-stage MIPS pipeline. It decodes the instruction in D and computes a Tuse for each source register and a Tnew for the destination. It tracks in-flight destinations in a shadow pipeline (E, M and W slots) that advances in lockstep with the datapath pipeline registers. It drives the forwarding selects consumed by the D, E and M stage multiplexers and the stall that freezes F/D and bubbles E.

## Interface
Parameters:
- none. All encodings come from `hazard_pkg`.

Ports:
- `clk` in 1: single pipeline clock, rising edge.
- `reset` in 1: synchronous, active-low. Clears all shadow slots.
- `Instr_D` in 32: instruction currently held in the D-stage register.
- `Stall` out 1: when high, F and D registers hold and the E register loads a bubble.
- `ForwardRSD` out 2: select for the D-stage rs compare/jump operand.
- `ForwardRTD` out 2: select for the D-stage rt compare operand.
- `ForwardRSE` out 2: select for the E-stage rs operand mux.
- `ForwardRTE` out 2: select for the E-stage rt operand mux.
- `ForwardRTM` out 1: selects the W write-back value for the M-stage store data.

Forward encoding for all 2-bit selects:
- 2'b00: register value carried in the pipeline.
- 2'b01: W-stage write-back value (`MUXRFWDOut`).
- 2'b10: M-stage `ALUOutput_M`.
- 2'b11: never driven.

## Operation
- Decode (from `Instr_D`): rs=[25:21], rt=[20:16].
  - Write address: rd for R-type, rt for I-type, 31 for jal, 0 for no write.
  - Tuse (rs/rt):
    - beq: 0/0.
    - bgez, jr: 0/—.
    - addu, subu: 1/1.
    - ori, lw: 1/—.
    - sw: 1/2.
    - lui, j, jal, nop: —/—.
  - Tnew at entry to E: addu/subu/ori/lui/jal = 1, lw = 2, others = 0.
  - Undefined opcodes decode as nop.
- Shadow slots:
  - E = {rs, rt, wa, tnew}.
  - M = {rt, wa, tnew}.
  - W = {wa}.
- Advance on each rising edge when `reset`=1:
  - M ← E with tnew decremented, saturating at 0.
  - W ← M.wa.
  - E ← decoded D fields, or a bubble (all zero) if `Stall`=1.
- Match rule: a source matches a slot iff the source is used (Tuse defined), its address ≠ 0, and it equals slot.wa.
- Stall is combinational:
  - Asserted if any used D source matches E with Tuse < E.tnew.
  - Or if any used D source matches M with Tuse < M.tnew.
- D forward selects:
  - 2'b10 if the source matches M and M.tnew = 0.
  - Else 2'b01 if it matches W.
  - Else 2'b00.
- E forward selects: same priority as D, using the E.rs and E.rt fields.
- `ForwardRTM`: 1 iff M.rt ≠ 0 and M.rt = W.wa.
- M beats W whenever both match.
- The register file has no internal write-through, so the W forward is mandatory.

## Timing
- Reset: on the first edge with `reset`=0, all slots are cleared.
  - After that edge: `Stall`=0, and all forward selects are 0, except D selects can still depend on `Instr_D`; they are 0 because the slots are empty.
  - Reset mid-stall discards the bubble/hold relationship. The datapath registers are reset on the same edge.
- Latency: all outputs are combinational from the slots plus `Instr_D`, and are valid within the same cycle.
- Slot updates take effect one edge later.
- lw followed by a dependent ALU op: exactly 1 stall cycle.
- lw followed by a dependent beq: 2 stall cycles.
- ALU op followed by a dependent beq: 1 stall cycle.
- Stall never persists more than 2 consecutive cycles for one D instruction.
- Writes to $0 never stall or forward.
- `Stall` and slot advance are simultaneous: the E bubble is inserted on the same edge at which the D instruction is held.

## Structure
- `hazard_pkg` holds:
  - opcode/funct constants;
  - the FWD_RF, FWD_W and FWD_M codes;
  - Tuse/Tnew constants, with "unused" represented as 3;
  - the slot struct typedefs.
- One sub-module, `hazard_decode`, is combinational: `Instr_D` → {rs, rt, wa, tuse_rs, tuse_rt, tnew}.
- The top module holds the slot registers, match logic, stall logic and select logic.

## Test plan
- Reset with `reset`=0 for 2 cycles while `Instr_D`=addu $3,$1,$2 → `Stall`=0, all selects 00. After release, the addu moves into E.
- addu $3,$1,$2 then addu $4,$3,$3 → no stall. With the second in E: `ForwardRSE`=`ForwardRTE`=10. One cycle later, with an unrelated op in E, nothing from W.
- lw $5,0($0) then ori $6,$5,1 → `Stall`=1 for exactly 1 cycle. Then `ForwardRSE`=01 with ori in E.
- ori $7,$0,9 then beq $7,$7 → `Stall`=1 for 1 cycle. Next cycle `ForwardRSD`=`ForwardRTD`=10.
- lw $8,0($0) then sw $8,4($0) → no stall. With sw in M: `ForwardRTM`=1.
- jal then jr $31 → 1-cycle stall, then `ForwardRSD`=10. Separately, addu $0,$1,$2 followed by a reader of $0 → never stall or forward.
